// File: rtl/uart_instr_loader.sv
// uart_instr_loader: UART (8N1, LSB first) receiver that packs received bytes
// big-endian into instruction words and writes them to consecutive
// instruction-memory addresses while Enable_Instruction_Input is high.
// Optional even-parity bit per frame: define UART_PARITY_EN.
// CLKS_PER_BIT must be even and >= 8; INSTR_WIDTH must be a multiple of 8.
module uart_instr_loader #(
    parameter int CLKS_PER_BIT = 64,
    parameter int INSTR_WIDTH  = 16,
    parameter int ADDR_WIDTH   = 8
) (
    input  logic                   CLOCK_50,
    input  logic                   rst,
    input  logic                   Enable_Instruction_Input,
    input  logic                   UART_RxD,
    output logic                   imem_we,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic [INSTR_WIDTH-1:0] imem_wdata,
    output logic [ADDR_WIDTH:0]    instr_count,
    output logic                   load_busy,
    output logic                   frame_error,
    output logic                   parity_error,
    output logic                   overflow
);

    localparam int NBYTES = INSTR_WIDTH / 8;
    localparam int PW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CW     = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0]         FULL_BIT   = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0]         HALF_BIT   = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [PW-1:0]         LAST_PHASE = PW'(NBYTES - 1);
    localparam logic [ADDR_WIDTH:0]   MEM_FULL   = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH-1:0] PTR_MAX    = '1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_DATA      = 3'd2;
`ifdef UART_PARITY_EN
    localparam logic [2:0] S_PARITY    = 3'd3;
`endif
    localparam logic [2:0] S_STOP      = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH = 3'd5;

    // Receiver registers
    logic                   sync1_q, sync2_q, prev_q;
    logic [2:0]             state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             bit_q, bit_d;
    logic [7:0]             shift_q, shift_d;
    logic                   rx_s;
    logic                   byte_ok;   // frame finished cleanly, byte in shift_q
    logic                   stop_low;  // stop bit sampled low this cycle
`ifdef UART_PARITY_EN
    logic                   par_bad_q, par_bad_d;
    logic                   par_fail;  // parity bit mismatched this cycle
`endif

    // Session / assembly registers
    logic                   en_prev_q;
    logic                   en_rise, en_fall;
    logic [PW-1:0]          phase_q, phase_d;
    logic [INSTR_WIDTH-1:0] word_q, word_d;
    logic [ADDR_WIDTH-1:0]  ptr_q, ptr_d;
    logic [ADDR_WIDTH:0]    count_q, count_d;
    logic                   we_q, we_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [INSTR_WIDTH-1:0] wdata_q, wdata_d;
    logic                   ferr_q, ferr_d;
    logic                   ovf_q, ovf_d;
`ifdef UART_PARITY_EN
    logic                   perr_q, perr_d;
`endif

    assign rx_s = sync2_q;

    // Two-flop synchroniser on the serial line plus a delayed copy for edge detect
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            sync1_q <= UART_RxD;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    // Receiver next-state: bit timing, sampling and frame checks
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        byte_ok  = 1'b0;
        stop_low = 1'b0;
`ifdef UART_PARITY_EN
        par_bad_d = par_bad_q;
        par_fail  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
                if (prev_q && !rx_s) begin
                    state_d = S_START;
                    cnt_d   = '0;
                end
            end
            S_START: begin
                if (cnt_q == HALF_BIT) begin
                    cnt_d = '0;
                    bit_d = '0;
`ifdef UART_PARITY_EN
                    par_bad_d = 1'b0;
`endif
                    // A start bit that is high again at mid-bit is a glitch
                    state_d = rx_s ? S_IDLE : S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            S_PARITY: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d     = '0;
                    par_fail  = (^shift_q) ^ rx_s;
                    par_bad_d = par_fail;
                    state_d   = S_STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            S_STOP: begin
                if (cnt_q == FULL_BIT) begin
                    cnt_d = '0;
                    if (rx_s) begin
`ifdef UART_PARITY_EN
                        byte_ok = !par_bad_q;
`else
                        byte_ok = 1'b1;
`endif
                        state_d = S_IDLE;
                    end else begin
                        stop_low = 1'b1;
                        state_d  = S_WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT_HIGH: begin
                if (rx_s) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Receiver state registers
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
`ifdef UART_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
`ifdef UART_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    assign en_rise = Enable_Instruction_Input && !en_prev_q;
    assign en_fall = !Enable_Instruction_Input && en_prev_q;

    // Word assembly, memory write strobe and session bookkeeping
    always_comb begin
        phase_d = phase_q;
        word_d  = word_q;
        ptr_d   = ptr_q;
        count_d = count_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        ferr_d  = ferr_q;
        ovf_d   = ovf_q;
`ifdef UART_PARITY_EN
        perr_d  = perr_q;
`endif
        // Advance the pointer the cycle after a write; the pointer never wraps
        if (we_q) begin
            count_d = count_q + 1'b1;
            if (ptr_q != PTR_MAX) begin
                ptr_d = ptr_q + 1'b1;
            end
        end
        if (stop_low) begin
            ferr_d  = 1'b1;
            phase_d = '0;
        end
`ifdef UART_PARITY_EN
        if (par_fail) begin
            perr_d  = 1'b1;
            phase_d = '0;
        end
`endif
        if (byte_ok && Enable_Instruction_Input) begin
            // First byte of a word ends up in the most significant position
            word_d = (word_q << 8) | INSTR_WIDTH'(shift_q);
            if (phase_q == LAST_PHASE) begin
                phase_d = '0;
                if (count_q == MEM_FULL) begin
                    ovf_d = 1'b1;
                end else begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = word_d;
                end
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
        if (en_fall) begin
            phase_d = '0;
        end
        // A new session wins over anything completing in the same cycle
        if (en_rise) begin
            phase_d = '0;
            ptr_d   = '0;
            count_d = '0;
            we_d    = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
`ifdef UART_PARITY_EN
            perr_d  = 1'b0;
`endif
        end
    end

    // Session state registers
    always_ff @(posedge CLOCK_50 or negedge rst) begin
        if (!rst) begin
            en_prev_q <= 1'b0;
            phase_q   <= '0;
            word_q    <= '0;
            ptr_q     <= '0;
            count_q   <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
`ifdef UART_PARITY_EN
            perr_q    <= 1'b0;
`endif
        end else begin
            en_prev_q <= Enable_Instruction_Input;
            phase_q   <= phase_d;
            word_q    <= word_d;
            ptr_q     <= ptr_d;
            count_q   <= count_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
`ifdef UART_PARITY_EN
            perr_q    <= perr_d;
`endif
        end
    end

    assign imem_we     = we_q;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign instr_count = count_q;
    assign load_busy   = (state_q != S_IDLE) || (phase_q != '0);
    assign frame_error = ferr_q;
    assign overflow    = ovf_q;
`ifdef UART_PARITY_EN
    assign parity_error = perr_q;
`else
    assign parity_error = 1'b0;
`endif

endmodule
